// File: rtl/water_inlet_arbiter_pkg.sv
// Shared types and constants for the water-inlet arbiter.
// Holds the arbiter state encoding, default parameter values and the width helper.
package wash_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_WASHERS     = 4;
    localparam int DEF_MAX_FILL_CYCLES = 1024;
    localparam int DEF_SWITCH_GAP      = 4;

    // Width of an index into n items. The result is never below one bit, so the
    // value stays usable when n is 1.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/water_inlet_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Finds the first eligible washer at or above last+1, wrapping at the top.
// Works by rotating the eligible vector, priority-encoding it, then un-rotating.
module rr_pick #(
    parameter int NUM_WASHERS = 4,
    parameter int SEL_W       = 2
) (
    input  logic [NUM_WASHERS-1:0] eligible,
    input  logic [SEL_W-1:0]       last,
    output logic                   found,
    output logic [SEL_W-1:0]       pick
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_WASHERS - 1);
    localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(NUM_WASHERS);

    logic [SEL_W-1:0]         start;
    logic [2*NUM_WASHERS-1:0] doubled;
    logic [2*NUM_WASHERS-1:0] shifted;
    logic [NUM_WASHERS-1:0]   rotated;
    logic [SEL_W-1:0]         offset;
    logic [SEL_W:0]           sum;

    // Rotate so that washer last+1 sits at bit 0.
    always_comb begin
        start   = (last == LAST_IDX) ? '0 : last + 1'b1;
        doubled = {eligible, eligible};
        shifted = doubled >> start;
        rotated = shifted[NUM_WASHERS-1:0];
    end

    // Priority-encode the rotated vector (lowest bit wins), then map the offset back to a washer index.
    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int k = NUM_WASHERS - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found  = 1'b1;
                offset = SEL_W'(k);
            end
        end
        sum  = {1'b0, offset} + {1'b0, start};
        pick = (sum >= N_EXT) ? SEL_W'(sum - N_EXT) : SEL_W'(sum);
    end

endmodule

// File: rtl/water_inlet_arbiter.sv
// Water-inlet arbiter: shares one inlet valve among several washer controllers.
// Round-robin grants, each bounded by a fill watchdog and followed by a closed-valve gap.
// All outputs are registered; reset is asynchronous and forces the valve closed immediately.
module water_inlet_arbiter
    import wash_pkg::*;
#(
    parameter int NUM_WASHERS     = DEF_NUM_WASHERS,
    parameter int MAX_FILL_CYCLES = DEF_MAX_FILL_CYCLES,
    parameter int SWITCH_GAP      = DEF_SWITCH_GAP
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_WASHERS-1:0]            fill_req,
    input  logic [NUM_WASHERS-1:0]            level_full,
    input  logic [NUM_WASHERS-1:0]            fault_clr,
    output logic [NUM_WASHERS-1:0]            grant,
    output logic                              valve_open,
    output logic [sel_w(NUM_WASHERS)-1:0]     valve_sel,
    output logic [NUM_WASHERS-1:0]            fill_fault,
    output logic                              busy
);

    localparam int SEL_W = sel_w(NUM_WASHERS);
    localparam int CNT_W = sel_w(MAX_FILL_CYCLES);
    localparam int GAP_W = sel_w(SWITCH_GAP);

    localparam logic [SEL_W-1:0]       LAST_INIT = SEL_W'(NUM_WASHERS - 1);
    localparam logic [CNT_W-1:0]       FILL_LAST = CNT_W'(MAX_FILL_CYCLES - 1);
    localparam logic [GAP_W-1:0]       GAP_LAST  = GAP_W'(SWITCH_GAP - 1);
    localparam logic [NUM_WASHERS-1:0] ONE_HOT0  = {{(NUM_WASHERS - 1){1'b0}}, 1'b1};

    arb_state_t             state_q, state_d;
    logic [SEL_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]       fill_cnt_q, fill_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;

    logic [NUM_WASHERS-1:0] grant_d;
    logic                   valve_open_d;
    logic [SEL_W-1:0]       valve_sel_d;
    logic [NUM_WASHERS-1:0] fill_fault_d;
    logic                   busy_d;

    logic [NUM_WASHERS-1:0] eligible;
    logic [NUM_WASHERS-1:0] fault_set;
    logic                   pick_found;
    logic [SEL_W-1:0]       pick_idx;
    logic                   release_now;

    // A washer competes only while requesting, not yet full and not faulted.
    always_comb begin
        eligible = fill_req & ~level_full & ~fill_fault;
    end

    rr_pick #(
        .NUM_WASHERS (NUM_WASHERS),
        .SEL_W       (SEL_W)
    ) u_rr_pick (
        .eligible (eligible),
        .last     (last_q),
        .found    (pick_found),
        .pick     (pick_idx)
    );

    // Next-state and next-output logic; every register holds unless a transition updates it.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        fill_cnt_d   = fill_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        grant_d      = grant;
        valve_open_d = valve_open;
        valve_sel_d  = valve_sel;
        fault_set    = '0;
        release_now  = level_full[valve_sel] | ~fill_req[valve_sel];

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d      = FILL;
                    grant_d      = ONE_HOT0 << pick_idx;
                    valve_open_d = 1'b1;
                    valve_sel_d  = pick_idx;
                    last_d       = pick_idx;
                    fill_cnt_d   = '0;
                end
            end
            FILL: begin
                // A release in the timeout cycle takes precedence, so no fault is raised.
                if (release_now) begin
                    state_d      = GAP;
                    grant_d      = '0;
                    valve_open_d = 1'b0;
                    gap_cnt_d    = '0;
                end else if (fill_cnt_q == FILL_LAST) begin
                    state_d      = GAP;
                    grant_d      = '0;
                    valve_open_d = 1'b0;
                    gap_cnt_d    = '0;
                    fault_set    = ONE_HOT0 << valve_sel;
                end else begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
            GAP: begin
                // valve_sel keeps its value so the manifold does not move while closed.
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                grant_d      = '0;
                valve_open_d = 1'b0;
            end
        endcase

        // A watchdog set outranks a clear arriving in the same cycle.
        fill_fault_d = (fill_fault & ~fault_clr) | fault_set;
        busy_d       = (state_d != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            last_q     <= LAST_INIT;
            fill_cnt_q <= '0;
            gap_cnt_q  <= '0;
            grant      <= '0;
            valve_open <= 1'b0;
            valve_sel  <= '0;
            fill_fault <= '0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            fill_cnt_q <= fill_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            grant      <= grant_d;
            valve_open <= valve_open_d;
            valve_sel  <= valve_sel_d;
            fill_fault <= fill_fault_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_water_inlet_arbiter.sv
// Testbench for water_inlet_arbiter with NUM_WASHERS=4, MAX_FILL_CYCLES=16, SWITCH_GAP=2.
// Expected grant indices are queued as stimulus is driven; a monitor pops them on each new grant.
module tb_water_inlet_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] fill_req = 4'b0;
    logic [3:0] level_full = 4'b0;
    logic [3:0] fault_clr = 4'b0;
    logic [3:0] grant;
    logic       valve_open;
    logic [1:0] valve_sel;
    logic [3:0] fill_fault;
    logic       busy;

    int tests_run = 0;
    int fails = 0;
    int exp_q[$];
    logic       mon_en = 1'b0;
    logic [3:0] prev_grant = 4'b0;

    water_inlet_arbiter #(
        .NUM_WASHERS     (4),
        .MAX_FILL_CYCLES (16),
        .SWITCH_GAP      (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fill_req   (fill_req),
        .level_full (level_full),
        .fault_clr  (fault_clr),
        .grant      (grant),
        .valve_open (valve_open),
        .valve_sel  (valve_sel),
        .fill_fault (fill_fault),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Output consistency on every cycle, plus grant-order scoreboard on each new grant.
    always @(negedge clk) begin
        int exp_i;
        if (mon_en) begin
            tests_run++;
            if ((valve_open !== (grant != 4'b0)) || !$onehot0(grant)) begin
                fails++;
                $display("FAIL consistency: grant=%b valve_open=%b, required one-hot-or-zero grant matching valve_open",
                         grant, valve_open);
            end
            if (grant !== 4'b0 && prev_grant === 4'b0) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL grant_order: got grant=%b, required no grant", grant);
                end else begin
                    exp_i = exp_q.pop_front();
                    if (grant !== (4'b1 << exp_i) || valve_sel !== 2'(exp_i)) begin
                        fails++;
                        $display("FAIL grant_order: got grant=%b sel=%0d, required washer %0d",
                                 grant, valve_sel, exp_i);
                    end
                end
            end
            prev_grant = grant;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        fill_req   = 4'b0;
        level_full = 4'b0;
        fault_clr  = 4'b0;
        reset      = 1'b1;
        tick(2);
        reset      = 1'b0;
    endtask

    task automatic wait_open(output int closed);
        closed = 0;
        while (valve_open !== 1'b1 && closed < 40) begin
            tick(1);
            if (valve_open !== 1'b1) closed++;
        end
        tests_run++;
        if (valve_open !== 1'b1) begin
            fails++;
            $display("FAIL wait_open: valve_open=%b after %0d cycles, required 1", valve_open, closed);
        end
    endtask

    task automatic hold_release(input int idx, input int hold);
        tick(hold - 1);
        level_full = level_full | (4'b1 << idx);
        tick(1);
        tests_run++;
        if (valve_open !== 1'b0 || grant !== 4'b0) begin
            fails++;
            $display("FAIL release_w%0d: valve_open=%b grant=%b, required 0 and 0000", idx, valve_open, grant);
        end
        level_full = level_full & ~(4'b1 << idx);
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (grant !== 4'b0 || valve_open !== 1'b0 || valve_sel !== 2'd0 ||
            fill_fault !== 4'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: grant=%b open=%b sel=%0d fault=%b busy=%b, required all zero",
                     grant, valve_open, valve_sel, fill_fault, busy);
        end
        tick(2);
        reset = 1'b0;
        tick(1);
        tests_run++;
        if (busy !== 1'b0 || grant !== 4'b0) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b grant=%b, required 0 and 0000", busy, grant);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic_fill();
        fill_req = 4'b0100;
        exp_q.push_back(2);
        tick(1);
        tests_run++;
        if (grant !== 4'b0100 || valve_sel !== 2'd2 || valve_open !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_grant: grant=%b sel=%0d open=%b busy=%b, required 0100 2 1 1",
                     grant, valve_sel, valve_open, busy);
        end
        tick(2);
        level_full = 4'b0100;
        tick(1);
        tests_run++;
        if (valve_open !== 1'b0 || grant !== 4'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_release: open=%b grant=%b busy=%b, required 0 0000 1", valve_open, grant, busy);
        end
        fill_req   = 4'b0;
        level_full = 4'b0;
        tick(1);
        tests_run++;
        if (busy !== 1'b1 || valve_sel !== 2'd2) begin
            fails++;
            $display("FAIL basic_gap: busy=%b sel=%0d, required 1 and 2", busy, valve_sel);
        end
        tick(1);
        tests_run++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_busy_fall: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int closed;
        do_reset();
        for (int g = 0; g < 5; g++) exp_q.push_back(g % 4);
        fill_req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_open(closed);
            if (g > 0) begin
                tests_run++;
                if (closed + 1 != 3) begin
                    fails++;
                    $display("FAIL rr_gap_%0d: closed cycles=%0d, required 3", g, closed + 1);
                end
            end
            hold_release(g % 4, 5);
        end
        fill_req = 4'b0;
        tick(4);
    endtask

    task automatic test_watchdog();
        int closed;
        int open_cycles;
        do_reset();
        fill_req = 4'b0010;
        exp_q.push_back(1);
        wait_open(closed);
        open_cycles = 1;
        while (valve_open === 1'b1 && open_cycles < 40) begin
            tick(1);
            if (valve_open === 1'b1) open_cycles++;
        end
        tests_run++;
        if (open_cycles != 16) begin
            fails++;
            $display("FAIL wd_open_cycles: got %0d, required 16", open_cycles);
        end
        tests_run++;
        if (fill_fault !== 4'b0010) begin
            fails++;
            $display("FAIL wd_fault_set: fill_fault=%b, required 0010", fill_fault);
        end
        fill_req = 4'b1011;
        exp_q.push_back(3);
        exp_q.push_back(0);
        wait_open(closed);
        hold_release(3, 3);
        wait_open(closed);
        hold_release(0, 3);
        fill_req  = 4'b0010;
        fault_clr = 4'b0010;
        tick(1);
        fault_clr = 4'b0;
        tests_run++;
        if (fill_fault !== 4'b0) begin
            fails++;
            $display("FAIL wd_fault_clr: fill_fault=%b, required 0000", fill_fault);
        end
        exp_q.push_back(1);
        wait_open(closed);
        hold_release(1, 3);
        fill_req = 4'b0;
        tick(4);
    endtask

    task automatic test_simultaneous();
        int closed;
        do_reset();
        fill_req = 4'b0100;
        exp_q.push_back(2);
        wait_open(closed);
        hold_release(2, 16);
        tests_run++;
        if (fill_fault !== 4'b0) begin
            fails++;
            $display("FAIL sim_release_wins: fill_fault=%b, required 0000", fill_fault);
        end
        exp_q.push_back(2);
        wait_open(closed);
        tick(15);
        fault_clr = 4'b0100;
        tick(1);
        fault_clr = 4'b0;
        fill_req  = 4'b0;
        tests_run++;
        if (fill_fault !== 4'b0100 || valve_open !== 1'b0) begin
            fails++;
            $display("FAIL sim_set_wins: fill_fault=%b open=%b, required 0100 and 0", fill_fault, valve_open);
        end
        tick(2);
        tests_run++;
        if (fill_fault !== 4'b0100) begin
            fails++;
            $display("FAIL sim_fault_sticky: fill_fault=%b, required 0100", fill_fault);
        end
        fault_clr = 4'b0100;
        tick(1);
        fault_clr = 4'b0;
        tests_run++;
        if (fill_fault !== 4'b0) begin
            fails++;
            $display("FAIL sim_fault_clear: fill_fault=%b, required 0000", fill_fault);
        end
        tick(2);
    endtask

    task automatic test_reset_mid_fill();
        int closed;
        do_reset();
        fill_req = 4'b0010;
        exp_q.push_back(1);
        wait_open(closed);
        tick(2);
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if (valve_open !== 1'b0 || grant !== 4'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: open=%b grant=%b busy=%b, required 0 0000 0", valve_open, grant, busy);
        end
        fill_req = 4'b0011;
        tick(1);
        reset = 1'b0;
        exp_q.push_back(0);
        exp_q.push_back(1);
        wait_open(closed);
        tests_run++;
        if (valve_sel !== 2'd0) begin
            fails++;
            $display("FAIL reset_priority: valve_sel=%0d, required 0", valve_sel);
        end
        hold_release(0, 3);
        fill_req = 4'b0010;
        wait_open(closed);
        hold_release(1, 3);
        fill_req = 4'b0;
        tick(4);
    endtask

    task automatic test_drop_while_waiting();
        int closed;
        logic seen;
        do_reset();
        fill_req = 4'b1001;
        exp_q.push_back(0);
        wait_open(closed);
        tick(1);
        fill_req = 4'b0001;
        hold_release(0, 4);
        fill_req = 4'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            if (grant !== 4'b0) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL drop_no_grant: grant seen=%b, required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_round_robin();
        test_watchdog();
        test_simultaneous();
        test_reset_mid_fill();
        test_drop_while_waiting();
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expected grants left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
